// File: rtl/rgmii_reset_pkg.sv
// Shared constants for the RGMII receive-side MAC reset sequencer.
package rgmii_reset_pkg;

  // Status vector layout: {link, speed[1:0], duplex}
  localparam int STATUS_W = 4;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rgmii_mac_reset_seq_if.sv
// Status-in / reset-out bundle between the PHY status source and the sequencer.
interface rgmii_mac_reset_seq_if #(
  parameter int N_RST = 2,
  parameter int CNT_W = 16
);

  logic             soft_rst;
  logic             inband_link_status;
  logic [1:0]       inband_clock_speed;
  logic             inband_duplex;
  logic [N_RST-1:0] rst_out;
  logic             link_up;
  logic [1:0]       speed_out;
  logic             duplex_out;
  logic [1:0]       seq_state;
  logic [CNT_W-1:0] change_cnt;

  modport master (
    output soft_rst, inband_link_status, inband_clock_speed, inband_duplex,
    input  rst_out, link_up, speed_out, duplex_out, seq_state, change_cnt
  );

  modport slave (
    input  soft_rst, inband_link_status, inband_clock_speed, inband_duplex,
    output rst_out, link_up, speed_out, duplex_out, seq_state, change_cnt
  );

endinterface

// File: rtl/rgmii_status_debounce.sv
// Synchronises the PHY in-band status and accepts a new value only after it
// has been stable for DEBOUNCE_CYCLES cycles. o_event is high on the cycle
// whose closing edge commits the new value, so the consumer reacts on the
// same edge that the accepted vector changes.
module rgmii_status_debounce
  import rgmii_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                rx_mac_aclk,
  input  logic                sys_rst,
  input  logic [STATUS_W-1:0] i_status,
  output logic [STATUS_W-1:0] o_accepted,
  output logic                o_event
);

  localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [STATUS_W-1:0] r_sync1;
  logic [STATUS_W-1:0] r_sync2;
  logic [STATUS_W-1:0] r_prev;
  logic [STATUS_W-1:0] r_accepted;
  logic [DB_W-1:0]     r_stab;
  logic                w_pending;

  assign w_pending  = (r_sync2 != r_accepted) && (r_sync2 == r_prev);
  assign o_event    = w_pending && (r_stab == DB_LAST);
  assign o_accepted = r_accepted;

  // Two-flop synchroniser, stability counter and accepted-vector commit
  always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_accepted <= '0;
      r_stab     <= '0;
    end else begin
      r_sync1 <= i_status;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_pending) begin
        r_stab <= '0;
      end else if (o_event) begin
        r_accepted <= r_sync2;
        r_stab     <= '0;
      end else begin
        r_stab <= r_stab + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgmii_mac_reset_seq.sv
// Staged reset sequencer for the RGMII receive MAC pipeline.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HOLD    | all resets asserted, hold timer running (may wait on link)
//   RELEASE | resets dropped one stage per STAGE_GAP cycles, bit 0 first
//   RUN     | all resets released until the next restart
module rgmii_mac_reset_seq
  import rgmii_reset_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int N_RST           = 2,
  parameter int STAGE_GAP       = 4,
  parameter int HOLD_WHILE_DOWN = 1,
  parameter int CNT_W           = 16
) (
  input logic                  rx_mac_aclk,
  input logic                  sys_rst,
  rgmii_mac_reset_seq_if.slave seq_if
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int STG_W  = (N_RST > 1) ? $clog2(N_RST) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_RST - 1);
  localparam bit                BLOCK_ON_DOWN = (HOLD_WHILE_DOWN != 0);

  logic [STATUS_W-1:0] w_status;
  logic [STATUS_W-1:0] w_accepted;
  logic                w_event;
  logic                w_restart;
  logic                w_hold_blocked;

  seq_state_e          r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic [GAP_W-1:0]    r_gap;
  logic [STG_W-1:0]    r_stage;
  logic [N_RST-1:0]    r_rst;
  logic [CNT_W-1:0]    r_change_cnt;

  assign w_status = {seq_if.inband_link_status, seq_if.inband_clock_speed,
                     seq_if.inband_duplex};

  rgmii_status_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .rx_mac_aclk (rx_mac_aclk),
    .sys_rst     (sys_rst),
    .i_status    (w_status),
    .o_accepted  (w_accepted),
    .o_event     (w_event)
  );

  assign w_restart      = w_event || seq_if.soft_rst;
  assign w_hold_blocked = BLOCK_ON_DOWN && !w_accepted[3];

  // Sequencer FSM: a restart from any state re-enters HOLD with counters cleared
  always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= HOLD;
      r_hold  <= '0;
      r_gap   <= '0;
      r_stage <= '0;
      r_rst   <= '1;
    end else if (w_restart) begin
      r_state <= HOLD;
      r_hold  <= '0;
      r_gap   <= '0;
      r_stage <= '0;
      r_rst   <= '1;
    end else begin
      case (r_state)
        HOLD: begin
          r_rst <= '1;
          if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
          end else if (!w_hold_blocked) begin
            r_state <= RELEASE;
            r_hold  <= '0;
            r_gap   <= '0;
            r_stage <= '0;
          end
        end
        RELEASE: begin
          if (r_gap != GAP_LAST) begin
            r_gap <= r_gap + 1'b1;
          end else begin
            r_gap          <= '0;
            r_rst[r_stage] <= 1'b0;
            if (r_stage == STG_LAST) begin
              r_state <= RUN;
              r_stage <= '0;
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end
        end
        RUN: begin
          r_rst <= '0;
        end
        default: begin
          r_state <= HOLD;
          r_hold  <= '0;
          r_gap   <= '0;
          r_stage <= '0;
          r_rst   <= '1;
        end
      endcase
    end
  end

  // Count accepted status changes only; saturates rather than wrapping
  always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_change_cnt <= '0;
    end else if (w_event && (r_change_cnt != '1)) begin
      r_change_cnt <= r_change_cnt + 1'b1;
    end
  end

  assign seq_if.rst_out    = r_rst;
  assign seq_if.seq_state  = r_state;
  assign seq_if.change_cnt = r_change_cnt;
  assign seq_if.link_up    = w_accepted[3];
  assign seq_if.speed_out  = w_accepted[2:1];
  assign seq_if.duplex_out = w_accepted[0];

endmodule

// File: tb/tb_rgmii_mac_reset_seq.sv
// Directed bench for rgmii_mac_reset_seq. A second instance with a 2-bit
// change counter and HOLD_WHILE_DOWN = 0 shares the same stimulus to exercise
// counter saturation and release with the link down.
module tb_rgmii_mac_reset_seq;
  import rgmii_reset_pkg::*;

  logic clk = 1'b0;
  logic sys_rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rgmii_mac_reset_seq_if #(.N_RST(2), .CNT_W(16)) bus ();
  rgmii_mac_reset_seq_if #(.N_RST(2), .CNT_W(2))  bus_sat ();

  assign bus_sat.soft_rst           = bus.soft_rst;
  assign bus_sat.inband_link_status = bus.inband_link_status;
  assign bus_sat.inband_clock_speed = bus.inband_clock_speed;
  assign bus_sat.inband_duplex      = bus.inband_duplex;

  rgmii_mac_reset_seq #(
    .HOLD_CYCLES(16), .DEBOUNCE_CYCLES(4), .N_RST(2), .STAGE_GAP(4),
    .HOLD_WHILE_DOWN(1), .CNT_W(16)
  ) dut (
    .rx_mac_aclk (clk),
    .sys_rst     (sys_rst),
    .seq_if      (bus.slave)
  );

  rgmii_mac_reset_seq #(
    .HOLD_CYCLES(16), .DEBOUNCE_CYCLES(4), .N_RST(2), .STAGE_GAP(4),
    .HOLD_WHILE_DOWN(0), .CNT_W(2)
  ) dut_sat (
    .rx_mac_aclk (clk),
    .sys_rst     (sys_rst),
    .seq_if      (bus_sat.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL reset_rst_out got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.seq_state); end
    checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL reset_link got=%b exp=0", bus.link_up); end
    checks++; if (bus.speed_out !== 2'b00) begin failures++; $display("FAIL reset_speed got=%b exp=00", bus.speed_out); end
    checks++; if (bus.duplex_out !== 1'b0) begin failures++; $display("FAIL reset_duplex got=%b exp=0", bus.duplex_out); end
    checks++; if (bus.change_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.change_cnt); end
  endtask

  // Status {0,1G,full} present from reset: commit at edge 7, then HOLD forever
  task automatic test_powerup();
    @(negedge clk); sys_rst = 1'b0;
    tick(6);
    checks++; if (bus.change_cnt !== 16'd0) begin failures++; $display("FAIL pu_cnt_pre got=%0d exp=0", bus.change_cnt); end
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL pu_rst_pre got=%b exp=11", bus.rst_out); end
    tick(1);
    checks++; if (bus.change_cnt !== 16'd1) begin failures++; $display("FAIL pu_cnt got=%0d exp=1", bus.change_cnt); end
    checks++; if (bus.speed_out !== SPEED_1G) begin failures++; $display("FAIL pu_speed got=%b exp=10", bus.speed_out); end
    checks++; if (bus.duplex_out !== 1'b1) begin failures++; $display("FAIL pu_duplex got=%b exp=1", bus.duplex_out); end
    checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL pu_link got=%b exp=0", bus.link_up); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL pu_state got=%0d exp=0", bus.seq_state); end
    tick(16);
    checks++; if (bus_sat.seq_state !== RELEASE) begin failures++; $display("FAIL pu_nohold_state got=%0d exp=1", bus_sat.seq_state); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL pu_blocked_state got=%0d exp=0", bus.seq_state); end
    tick(14);
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL pu_rst_late got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL pu_state_late got=%0d exp=0", bus.seq_state); end
  endtask

  // Link up: commit 6 edges after the first capture edge, then 20/24 to release
  task automatic test_link_up();
    @(negedge clk); bus.inband_link_status = 1'b1;
    tick(6);
    checks++; if (bus.change_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt_pre got=%0d exp=1", bus.change_cnt); end
    checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL lu_link_pre got=%b exp=0", bus.link_up); end
    tick(1);
    checks++; if (bus.change_cnt !== 16'd2) begin failures++; $display("FAIL lu_cnt got=%0d exp=2", bus.change_cnt); end
    checks++; if (bus.link_up !== 1'b1) begin failures++; $display("FAIL lu_link got=%b exp=1", bus.link_up); end
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL lu_rst_commit got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL lu_state_commit got=%0d exp=0", bus.seq_state); end
    tick(19);
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL lu_rst_19 got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== RELEASE) begin failures++; $display("FAIL lu_state_19 got=%0d exp=1", bus.seq_state); end
    tick(1);
    checks++; if (bus.rst_out !== 2'b10) begin failures++; $display("FAIL lu_rst_20 got=%b exp=10", bus.rst_out); end
    tick(4);
    checks++; if (bus.rst_out !== 2'b00) begin failures++; $display("FAIL lu_rst_24 got=%b exp=00", bus.rst_out); end
    checks++; if (bus.seq_state !== RUN) begin failures++; $display("FAIL lu_state_24 got=%0d exp=2", bus.seq_state); end
  endtask

  task automatic test_glitch();
    @(negedge clk); bus.inband_link_status = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.inband_link_status = 1'b1;
    tick(12);
    checks++; if (bus.rst_out !== 2'b00) begin failures++; $display("FAIL gl_rst got=%b exp=00", bus.rst_out); end
    checks++; if (bus.change_cnt !== 16'd2) begin failures++; $display("FAIL gl_cnt got=%0d exp=2", bus.change_cnt); end
    checks++; if (bus.link_up !== 1'b1) begin failures++; $display("FAIL gl_link got=%b exp=1", bus.link_up); end
    checks++; if (bus.seq_state !== RUN) begin failures++; $display("FAIL gl_state got=%0d exp=2", bus.seq_state); end
  endtask

  // Lone soft_rst, then a speed change timed so its commit lands while rst_out = 10
  task automatic test_soft_and_speed();
    @(negedge clk); bus.soft_rst = 1'b1;
    tick(1);
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL sr_rst got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL sr_state got=%0d exp=0", bus.seq_state); end
    checks++; if (bus.change_cnt !== 16'd2) begin failures++; $display("FAIL sr_cnt got=%0d exp=2", bus.change_cnt); end
    @(negedge clk); bus.soft_rst = 1'b0;
    tick(16);
    checks++; if (bus.seq_state !== RELEASE) begin failures++; $display("FAIL sr_state_16 got=%0d exp=1", bus.seq_state); end
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL sr_rst_16 got=%b exp=11", bus.rst_out); end
    @(negedge clk); bus.inband_clock_speed = SPEED_100M;
    tick(5);
    checks++; if (bus.rst_out !== 2'b10) begin failures++; $display("FAIL sp_rst_mid got=%b exp=10", bus.rst_out); end
    tick(1);
    checks++; if (bus.speed_out !== SPEED_1G) begin failures++; $display("FAIL sp_speed_pre got=%b exp=10", bus.speed_out); end
    checks++; if (bus.change_cnt !== 16'd2) begin failures++; $display("FAIL sp_cnt_pre got=%0d exp=2", bus.change_cnt); end
    tick(1);
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL sp_rst_commit got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL sp_state_commit got=%0d exp=0", bus.seq_state); end
    checks++; if (bus.speed_out !== SPEED_100M) begin failures++; $display("FAIL sp_speed got=%b exp=01", bus.speed_out); end
    checks++; if (bus.change_cnt !== 16'd3) begin failures++; $display("FAIL sp_cnt got=%0d exp=3", bus.change_cnt); end
    checks++; if (bus_sat.change_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt_3 got=%0d exp=3", bus_sat.change_cnt); end
    tick(20);
    checks++; if (bus.rst_out !== 2'b10) begin failures++; $display("FAIL sp_rst_20 got=%b exp=10", bus.rst_out); end
    tick(4);
    checks++; if (bus.rst_out !== 2'b00) begin failures++; $display("FAIL sp_rst_24 got=%b exp=00", bus.rst_out); end
    checks++; if (bus.seq_state !== RUN) begin failures++; $display("FAIL sp_state_24 got=%0d exp=2", bus.seq_state); end
  endtask

  // Duplex commit and soft_rst sampled on the same edge
  task automatic test_back_to_back();
    @(negedge clk); bus.inband_duplex = 1'b0;
    tick(6);
    checks++; if (bus.change_cnt !== 16'd3) begin failures++; $display("FAIL bb_cnt_pre got=%0d exp=3", bus.change_cnt); end
    checks++; if (bus.seq_state !== RUN) begin failures++; $display("FAIL bb_state_pre got=%0d exp=2", bus.seq_state); end
    checks++; if (bus.duplex_out !== 1'b1) begin failures++; $display("FAIL bb_duplex_pre got=%b exp=1", bus.duplex_out); end
    @(negedge clk); bus.soft_rst = 1'b1;
    tick(1);
    checks++; if (bus.change_cnt !== 16'd4) begin failures++; $display("FAIL bb_cnt got=%0d exp=4", bus.change_cnt); end
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL bb_rst got=%b exp=11", bus.rst_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL bb_state got=%0d exp=0", bus.seq_state); end
    checks++; if (bus.duplex_out !== 1'b0) begin failures++; $display("FAIL bb_duplex got=%b exp=0", bus.duplex_out); end
    checks++; if (bus_sat.change_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt_hold got=%0d exp=3", bus_sat.change_cnt); end
    @(negedge clk); bus.soft_rst = 1'b0;
    tick(19);
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL bb_rst_19 got=%b exp=11", bus.rst_out); end
    tick(1);
    checks++; if (bus.rst_out !== 2'b10) begin failures++; $display("FAIL bb_rst_20 got=%b exp=10", bus.rst_out); end
    checks++; if (bus.seq_state !== RELEASE) begin failures++; $display("FAIL bb_state_20 got=%0d exp=1", bus.seq_state); end
  endtask

  // sys_rst asserted during RELEASE, then the sequence restarts from edge 1
  task automatic test_sys_rst_mid();
    @(negedge clk); sys_rst = 1'b1;
    #1;
    checks++; if (bus.rst_out !== 2'b11) begin failures++; $display("FAIL ar_rst got=%b exp=11", bus.rst_out); end
    checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL ar_link got=%b exp=0", bus.link_up); end
    checks++; if (bus.change_cnt !== 16'd0) begin failures++; $display("FAIL ar_cnt got=%0d exp=0", bus.change_cnt); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL ar_state got=%0d exp=0", bus.seq_state); end
    checks++; if (bus.speed_out !== 2'b00) begin failures++; $display("FAIL ar_speed got=%b exp=00", bus.speed_out); end
    checks++; if (bus_sat.change_cnt !== 2'd0) begin failures++; $display("FAIL ar_sat_cnt got=%0d exp=0", bus_sat.change_cnt); end
    @(negedge clk); sys_rst = 1'b0;
    tick(6);
    checks++; if (bus.change_cnt !== 16'd0) begin failures++; $display("FAIL rr_cnt_pre got=%0d exp=0", bus.change_cnt); end
    checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL rr_link_pre got=%b exp=0", bus.link_up); end
    tick(1);
    checks++; if (bus.change_cnt !== 16'd1) begin failures++; $display("FAIL rr_cnt got=%0d exp=1", bus.change_cnt); end
    checks++; if (bus.link_up !== 1'b1) begin failures++; $display("FAIL rr_link got=%b exp=1", bus.link_up); end
    checks++; if (bus.speed_out !== SPEED_100M) begin failures++; $display("FAIL rr_speed got=%b exp=01", bus.speed_out); end
    checks++; if (bus.seq_state !== HOLD) begin failures++; $display("FAIL rr_state got=%0d exp=0", bus.seq_state); end
    tick(20);
    checks++; if (bus.rst_out !== 2'b10) begin failures++; $display("FAIL rr_rst_27 got=%b exp=10", bus.rst_out); end
    tick(4);
    checks++; if (bus.rst_out !== 2'b00) begin failures++; $display("FAIL rr_rst_31 got=%b exp=00", bus.rst_out); end
    checks++; if (bus.seq_state !== RUN) begin failures++; $display("FAIL rr_state_31 got=%0d exp=2", bus.seq_state); end
  endtask

  initial begin
    sys_rst                = 1'b1;
    bus.soft_rst           = 1'b0;
    bus.inband_link_status = 1'b0;
    bus.inband_clock_speed = SPEED_1G;
    bus.inband_duplex      = 1'b1;
    tick(3);
    test_reset();
    test_powerup();
    test_link_up();
    test_glitch();
    test_soft_and_speed();
    test_back_to_back();
    test_sys_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgmii_mac_reset_seq.md
# rgmii_mac_reset_seq

Parametrised MAC reset sequencer for the RGMII receive clock domain: watches the PHY in-band status (link, speed, duplex) and drives a bank of staged, active-high resets for the downstream MAC pipeline. Status changes are synchronised and debounced before they act. Any accepted change, or a software request, restarts a hold/release sequence that deasserts the resets one stage at a time. It replaces the fixed single-output, link-edge-only reset generator on the receive side.

## Interface
- HOLD_CYCLES, 16: cycles all resets are held after a restart; legal range ≥2.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a new status; legal range ≥1.
- N_RST, 2: number of staged reset outputs; legal range 1..8.
- STAGE_GAP, 4: cycles between successive stage releases; legal range ≥1.
- HOLD_WHILE_DOWN, 1: 1 = stay in HOLD while the accepted link is down; 0 = release regardless of link.
- CNT_W, 16: width of the status-change counter.
- rx_mac_aclk  in  1  clock; all logic is in this domain.
- sys_rst  in  1  reset, asynchronous, active-high.
- soft_rst  in  1  synchronous request pulse; restarts the sequence.
- inband_link_status  in  1  PHY link (1 = up); treated as asynchronous.
- inband_clock_speed  in  2  PHY speed: 00 = 10M, 01 = 100M, 10 = 1G, 11 = reserved.
- inband_duplex  in  1  PHY duplex (1 = full).
- rst_out  out  N_RST  staged resets, active-high; bit 0 releases first.
- link_up  out  1  accepted link status.
- speed_out  out  2  accepted speed.
- duplex_out  out  1  accepted duplex.
- seq_state  out  2  current FSM state encoding.
- change_cnt  out  CNT_W  count of accepted status changes; saturating.

## Operation
- Status vector S = {link, speed, duplex} (4 bits) passes through a 2-FF synchroniser.
- Debounce:
  - A stability counter increments while the synchronised S differs from the accepted vector A and equals its value on the previous cycle.
  - The counter clears when the synchronised S changes or equals A.
  - When the count reaches DEBOUNCE_CYCLES, S is committed to A. This commit is an "event".
- Outputs link_up, speed_out and duplex_out are the fields of A.
- Reserved speed 11 is accepted like any other value.
- FSM states (package constants): HOLD = 0, RELEASE = 1, RUN = 2. Encoding 3 is illegal and recovers to HOLD.
- HOLD:
  - All rst_out = 1; the hold counter increments each cycle.
  - Exit to RELEASE once the counter has reached HOLD_CYCLES.
  - If HOLD_WHILE_DOWN = 1 and A.link = 0, exit is blocked; the counter saturates and waits.
- RELEASE:
  - A gap counter counts STAGE_GAP cycles, then deasserts rst_out[k], with k counting upward from 0.
  - The gap counter then restarts for the next stage.
  - On deassertion of rst_out[N_RST-1], the FSM moves to RUN.
- RUN: all rst_out = 0 until a restart.
- Restart (event or soft_rst, in any state):
  - Next state is HOLD; hold, gap and stage counters clear; all rst_out = 1 from the same edge.
- change_cnt increments by 1 per event and saturates at all-ones. soft_rst does not count.
- Event and soft_rst on the same cycle produce a single restart; change_cnt increments by 1.
- Reset values (sys_rst = 1):
  - seq_state = HOLD; rst_out all 1s.
  - A = 0, so link_up = 0, speed_out = 00, duplex_out = 0.
  - change_cnt = 0; all counters and synchronisers = 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Edge 1 is the first rising edge with sys_rst low.
- With no event, HOLD → RELEASE occurs at edge HOLD_CYCLES.
- rst_out[k] falls at edge HOLD_CYCLES + (k+1)·STAGE_GAP.
- RUN is entered on the same edge as rst_out[N_RST-1] falls.
- Status change:
  - Let edge e be the first edge at which the synchroniser captures the new value.
  - The event and commit occur at edge e + 1 + DEBOUNCE_CYCLES.
  - On that same edge, rst_out goes all 1s, seq_state = HOLD, and A and change_cnt update.
- Glitches stable for fewer than DEBOUNCE_CYCLES synchronised cycles are ignored entirely.
- soft_rst sampled high at edge t: rst_out all 1s and seq_state = HOLD from edge t.
- sys_rst assertion mid-sequence forces all reset values immediately (asynchronous). Release of sys_rst restarts the sequence from edge 1.

## Structure
- Package rgmii_reset_pkg holds:
  - the FSM state constants;
  - the speed encodings (SPEED_10M, SPEED_100M, SPEED_1G);
  - the status-vector width constant (4).
- Sub-module rgmii_status_debounce:
  - contains the 2-FF synchroniser, stability counter and accepted-vector register;
  - outputs A and a one-cycle event strobe.
- The top level contains the FSM, the stage/gap/hold counters and change_cnt.

## Test plan
All scenarios use the defaults: HOLD_CYCLES = 16, DEBOUNCE_CYCLES = 4, N_RST = 2, STAGE_GAP = 4.
- **Power-up, link down, HOLD_WHILE_DOWN = 1.** Status = {0,10,1}, sys_rst released. Expect: the event commits A = {0,10,1} and change_cnt = 1; rst_out stays 11 indefinitely.
- **Link up.** Raise link to 1 with speed 10. Expect: commit at e+5, change_cnt = 2, rst_out = 11 at commit. rst_out = 10 at commit+20, rst_out = 00 at commit+24, seq_state = RUN.
- **Glitch rejection.** In RUN, pulse link low for 3 cycles. Expect: rst_out stays 00, change_cnt unchanged, link_up stays 1.
- **Speed change mid-RELEASE.** Change speed 10 → 01 while rst_out = 10. Expect: rst_out returns to 11 at the commit edge, speed_out = 01, and the full hold/release sequence reruns.
- **soft_rst with simultaneous event.** Pulse soft_rst in RUN on the same cycle as a duplex commit. Expect: a single restart and change_cnt +1. A lone soft_rst pulse gives a restart with change_cnt unchanged.
- **sys_rst mid-RELEASE.** Assert sys_rst during RELEASE. Expect: rst_out = 11, link_up = 0, change_cnt = 0 immediately. With change_cnt preset near all-ones, further events saturate the counter without wrapping to 0.
